// File: rtl/dda_host_pkg.sv
// dda_host_pkg: shared opcodes and FSM state types for the DDA host interface.
//   OP_*        : command byte encodings decoded by the RX side
//   rx_state_t  : command/payload receive states
//   tx_state_t  : snapshot serializer states
package dda_host_pkg;

   // Upper nibble of a parameter write command; lower nibble is the index.
   localparam logic [3:0] OP_WRITE  = 4'h1;
   localparam logic [7:0] OP_COMMIT = 8'h20;
   localparam logic [7:0] OP_RUN    = 8'h30;
   localparam logic [7:0] OP_HALT   = 8'h31;
   localparam logic [7:0] OP_SNAP   = 8'h40;
   localparam logic [7:0] OP_CLRERR = 8'h50;

   typedef enum logic {RX_CMD, RX_PAYLOAD} rx_state_t;
   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

endpackage

// File: rtl/dda_tx_serializer.sv
// dda_tx_serializer: latches a W-bit snapshot and streams it MSB byte first
// over a valid/ready byte channel.
//   clk, rst  : clock, synchronous active-high reset
//   start     : latch data and begin streaming (ignored while busy)
//   data      : snapshot vector
//   tx_ready  : sink accepts tx_byte this cycle
//   tx_valid  : tx_byte is valid
//   tx_byte   : current byte
//   busy      : stream in progress
module dda_tx_serializer
   import dda_host_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] data,
   input  logic         tx_ready,
   output logic         tx_valid,
   output logic [7:0]   tx_byte,
   output logic         busy
);

   localparam int unsigned NB = W / 8;
   localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;

   tx_state_t     state_q, state_d;
   logic [W-1:0]  shift_q, shift_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= TX_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   // The snapshot shifts out through the top byte; once fully sent the
   // register is all zero, so tx_byte reads 0 while idle.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      case (state_q)
         TX_IDLE: begin
            if (start) begin
               shift_d = data;
               cnt_d   = '0;
               state_d = TX_SEND;
            end
         end
         TX_SEND: begin
            if (tx_ready) begin
               shift_d = shift_q << 8;
               if (cnt_q == CW'(NB - 1)) begin
                  cnt_d   = '0;
                  state_d = TX_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   assign tx_valid = (state_q == TX_SEND);
   assign busy     = (state_q == TX_SEND);
   assign tx_byte  = shift_q[W-1 -: 8];

endmodule

// File: rtl/dda_host_if.sv
// dda_host_if: byte-oriented host interface for the posit DDA core.
// Decodes command bytes, writes a shadow parameter bank, commits it
// atomically to the active bank, controls run/load and streams state
// snapshots back.
//   clk, rst          : clock, synchronous active-high reset
//   rx_valid, rx_byte : received byte strobe and data
//   state             : DDA state vector, state[0] in the top word
//   params            : active parameter bank, param 0 in the top word
//   dda_en, dda_load  : run enable, one-cycle reload pulse
//   tx_valid, tx_byte, tx_ready : snapshot byte stream
//   busy              : snapshot stream in progress
//   err               : sticky protocol error
module dda_host_if
   import dda_host_pkg::*;
#(
   parameter int unsigned N          = 16,
   parameter int unsigned NUM_PARAMS = 4,
   parameter int unsigned NUM_STATE  = 2,
   parameter logic [NUM_PARAMS*N-1:0] DEFAULTS = 64'hC000_14CD_7240_0800
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rx_valid,
   input  logic [7:0]              rx_byte,
   input  logic [NUM_STATE*N-1:0]  state,
   output logic [NUM_PARAMS*N-1:0] params,
   output logic                    dda_en,
   output logic                    dda_load,
   output logic                    tx_valid,
   output logic [7:0]              tx_byte,
   input  logic                    tx_ready,
   output logic                    busy,
   output logic                    err
);

   localparam int unsigned WB = N / 8;
   localparam int unsigned CW = (WB > 1) ? $clog2(WB) : 1;
   localparam int unsigned PW = NUM_PARAMS * N;

   rx_state_t     rx_state_q, rx_state_d;
   logic [3:0]    idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] shadow_q, shadow_d;
   logic [PW-1:0] active_q, active_d;
   logic          en_q, en_d;
   logic          load_q, load_d;
   logic          err_q, err_d;
   logic          err_set, err_clr;
   logic          snap_start;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state_q <= RX_CMD;
         idx_q      <= '0;
         cnt_q      <= '0;
         shadow_q   <= DEFAULTS;
         active_q   <= DEFAULTS;
         en_q       <= 1'b1;
         load_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         shadow_q   <= shadow_d;
         active_q   <= active_d;
         en_q       <= en_d;
         load_q     <= load_d;
         err_q      <= err_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      shadow_d   = shadow_q;
      active_d   = active_q;
      en_d       = en_q;
      load_d     = 1'b0;
      err_set    = 1'b0;
      err_clr    = 1'b0;
      snap_start = 1'b0;

      case (rx_state_q)
         RX_CMD: begin
            if (rx_valid) begin
               if (rx_byte[7:4] == OP_WRITE) begin
                  if ({1'b0, rx_byte[3:0]} < 5'(NUM_PARAMS)) begin
                     rx_state_d = RX_PAYLOAD;
                     idx_d      = rx_byte[3:0];
                     cnt_d      = '0;
                  end else begin
                     err_set = 1'b1;
                  end
               end else begin
                  case (rx_byte)
                     OP_COMMIT: begin
                        active_d = shadow_q;
                        load_d   = 1'b1;
                     end
                     OP_RUN:  en_d = 1'b1;
                     OP_HALT: en_d = 1'b0;
                     OP_SNAP: begin
                        if (busy) err_set = 1'b1;
                        else      snap_start = 1'b1;
                     end
                     OP_CLRERR: err_clr = 1'b1;
                     default:   err_set = 1'b1;
                  endcase
               end
            end
         end
         RX_PAYLOAD: begin
            if (rx_valid) begin
               // Word p sits at the top for p = 0; byte b is MSB first.
               for (int p = 0; p < int'(NUM_PARAMS); p++) begin
                  for (int b = 0; b < int'(WB); b++) begin
                     if (idx_q == 4'(p) && cnt_q == CW'(b)) begin
                        shadow_d[(NUM_PARAMS - 1 - p) * N + N - 1 - 8 * b -: 8] = rx_byte;
                     end
                  end
               end
               if (cnt_q == CW'(WB - 1)) begin
                  rx_state_d = RX_CMD;
                  cnt_d      = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: rx_state_d = RX_CMD;
      endcase

      // A clear in the same cycle as a new error leaves err low.
      if (err_clr)      err_d = 1'b0;
      else if (err_set) err_d = 1'b1;
      else              err_d = err_q;
   end

   dda_tx_serializer #(
      .W (NUM_STATE * N)
   ) u_tx (
      .clk      (clk),
      .rst      (rst),
      .start    (snap_start),
      .data     (state),
      .tx_ready (tx_ready),
      .tx_valid (tx_valid),
      .tx_byte  (tx_byte),
      .busy     (busy)
   );

   assign params   = active_q;
   assign dda_en   = en_q;
   assign dda_load = load_q;
   assign err      = err_q;

endmodule

// File: tb/tb_dda_host_if.sv
// tb_dda_host_if: lockstep bench for dda_host_if. A behavioural model of the
// command protocol (parameter word arrays, pending-byte queue) is stepped on
// every clock edge and all outputs are compared one time unit later.
module tb_dda_host_if;

   localparam int N  = 16;
   localparam int NP = 4;
   localparam int NS = 2;
   localparam int WB = N / 8;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            rx_valid = 1'b0;
   logic [7:0]      rx_byte = 8'h00;
   logic [NS*N-1:0] state = '0;
   logic [NP*N-1:0] params;
   logic            dda_en, dda_load, tx_valid, busy, err;
   logic [7:0]      tx_byte;
   logic            tx_ready = 1'b1;

   always #5 clk = ~clk;

   dda_host_if #(
      .N          (N),
      .NUM_PARAMS (NP),
      .NUM_STATE  (NS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .rx_valid (rx_valid),
      .rx_byte  (rx_byte),
      .state    (state),
      .params   (params),
      .dda_en   (dda_en),
      .dda_load (dda_load),
      .tx_valid (tx_valid),
      .tx_byte  (tx_byte),
      .tx_ready (tx_ready),
      .busy     (busy),
      .err      (err)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model
   logic [15:0] defs [NP] = '{16'hC000, 16'h14CD, 16'h7240, 16'h0800};
   logic [15:0] m_sh [NP];
   logic [15:0] m_ac [NP];
   logic [15:0] st_w [NS];
   logic [7:0]  q [$];
   bit          m_en, m_load, m_err, m_pay;
   int          m_k, m_j;

   task automatic model_reset();
      for (int i = 0; i < NP; i++) begin
         m_sh[i] = defs[i];
         m_ac[i] = defs[i];
      end
      m_en = 1; m_load = 0; m_err = 0; m_pay = 0; m_k = 0; m_j = 0;
      q.delete();
   endtask

   task automatic model_step(input bit v, input logic [7:0] b, input bit rdy);
      bit busy_pre = (q.size() != 0);
      bit set_e = 0;
      bit clr_e = 0;
      m_load = 0;
      if (busy_pre && rdy) void'(q.pop_front());
      if (v) begin
         if (m_pay) begin
            m_sh[m_k][N-1-8*m_j -: 8] = b;
            m_j++;
            if (m_j == WB) m_pay = 0;
         end else if (b[7:4] == 4'h1) begin
            if (int'(b[3:0]) < NP) begin
               m_pay = 1; m_k = int'(b[3:0]); m_j = 0;
            end else set_e = 1;
         end else begin
            case (b)
               8'h20: begin
                  for (int i = 0; i < NP; i++) m_ac[i] = m_sh[i];
                  m_load = 1;
               end
               8'h30: m_en = 1;
               8'h31: m_en = 0;
               8'h40: begin
                  if (busy_pre) set_e = 1;
                  else
                     for (int s = 0; s < NS; s++)
                        for (int j = 0; j < WB; j++) q.push_back(st_w[s][N-1-8*j -: 8]);
               end
               8'h50: clr_e = 1;
               default: set_e = 1;
            endcase
         end
      end
      if (clr_e) m_err = 0;
      else if (set_e) m_err = 1;
   endtask

   task automatic compare_all();
      logic [63:0] exp_p = {m_ac[0], m_ac[1], m_ac[2], m_ac[3]};
      bit          pend = (q.size() != 0);
      logic [7:0]  exp_b = pend ? q[0] : 8'h00;
      check("params",   64'(params),   exp_p);
      check("dda_en",   64'(dda_en),   64'(m_en));
      check("dda_load", 64'(dda_load), 64'(m_load));
      check("err",      64'(err),      64'(m_err));
      check("busy",     64'(busy),     64'(pend));
      check("tx_valid", 64'(tx_valid), 64'(pend));
      check("tx_byte",  64'(tx_byte),  64'(exp_b));
   endtask

   // One clock: drive inputs, let the edge happen, advance model, compare.
   task automatic cycle(input bit v, input logic [7:0] b, input bit rdy);
      rx_valid = v;
      rx_byte  = b;
      tx_ready = rdy;
      state    = {st_w[0], st_w[1]};
      @(posedge clk);
      if (rst) model_reset();
      else     model_step(v, b, rdy);
      #1;
      compare_all();
   endtask

   task automatic send(input logic [7:0] b);
      cycle(1, b, 1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(0, 8'h00, 1);
   endtask

   initial begin
      st_w[0] = 16'h0000;
      st_w[1] = 16'h0000;
      model_reset();
      rst = 1;
      idle(2);
      rst = 0;
      idle(1);

      // Shadow write does not reach params until commit
      send(8'h11); send(8'hAB); send(8'hCD);
      idle(5);
      send(8'h20);
      idle(2);
      send(8'h20); send(8'h20);
      idle(1);

      // Snapshot with free-running ready
      st_w[0] = 16'h1234; st_w[1] = 16'h5678;
      send(8'h40);
      st_w[0] = 16'hFFFF; st_w[1] = 16'hEEEE;
      idle(6);

      // Snapshot with ready asserted one cycle in three
      st_w[0] = 16'h1234; st_w[1] = 16'h5678;
      cycle(1, 8'h40, 0);
      for (int i = 0; i < 15; i++) cycle(0, 8'h00, (i % 3) == 2);

      // Second snapshot during a stream is rejected
      cycle(1, 8'h40, 0);
      cycle(0, 8'h00, 1);
      cycle(1, 8'h40, 0);
      cycle(1, 8'h50, 1);
      idle(5);

      // Out-of-range write index, following byte decoded as command
      send(8'h14);
      send(8'h31);
      idle(1);
      send(8'h50);
      send(8'h30);

      // Reset in the middle of a payload
      send(8'h10); send(8'hEE);
      rst = 1;
      idle(1);
      rst = 0;
      send(8'h20);
      send(8'h31);
      send(8'h30);
      idle(1);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         bit         v   = ($urandom_range(0, 2) != 0);
         bit         rdy = ($urandom_range(0, 3) != 0);
         logic [7:0] b;
         case ($urandom_range(0, 9))
            0, 1, 2: b = 8'h10 | 8'($urandom_range(0, 5));
            3:       b = 8'h20;
            4:       b = $urandom_range(0, 1) ? 8'h30 : 8'h31;
            5:       b = 8'h40;
            6:       b = 8'h50;
            default: b = 8'($urandom);
         endcase
         if ($urandom_range(0, 15) == 0) begin
            st_w[0] = 16'($urandom);
            st_w[1] = 16'($urandom);
         end
         rst = ($urandom_range(0, 499) == 0);
         cycle(v, b, rdy);
      end
      rst = 0;
      idle(12);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
